// File: rtl/csa_stream_accumulator_pkg.sv
// Shared types and width helpers for the carry-save stream accumulator.
// Guard bits cover the growth of a MAX_BEATS-operand sum so overflow is exact.
package csa_pkg;

  typedef enum logic [1:0] {
    ACC     = 2'd0,
    RESOLVE = 2'd1,
    OUT     = 2'd2
  } state_t;

  function automatic int guard_w(input int max_beats);
    return $clog2(max_beats);
  endfunction

  function automatic int ext_w(input int width, input int max_beats);
    return width + $clog2(max_beats);
  endfunction

  function automatic int cnt_w(input int max_beats);
    return $clog2(max_beats) + 1;
  endfunction

endpackage

// File: rtl/csa_stream_accumulator_row.sv
// Combinational 3:2 compressor row: per-bit full adders with no carry chain.
// The carry row is pre-shifted into weight position; the carry out of the MSB is dropped.
module csa_row #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);

  logic [W-1:0] maj;

  assign sum   = a ^ b ^ c;
  assign maj   = (a & b) | (a & c) | (b & c);
  assign carry = {maj[W-2:0], 1'b0};

endmodule

// File: rtl/csa_stream_accumulator.sv
// Streaming multi-operand adder holding its running total in carry-save form;
// one carry-propagate add per packet resolves the total and overflow flag.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ACC     | accepting beats, compressing each into sum_r/carry_r
// RESOLVE | one cycle: CPA of sum_r + carry_r into the output registers
// OUT     | result presented, held until out_ready; then clear and ACC
module csa_stream_accumulator
  import csa_pkg::*;
#(
  parameter  int WIDTH     = 64,
  parameter  int MAX_BEATS = 256,
  localparam int CNT_W     = cnt_w(MAX_BEATS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_count
);

  localparam int EXT = ext_w(WIDTH, MAX_BEATS);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);

  state_t           state_q, state_d;
  logic [EXT-1:0]   sum_r, carry_r;
  logic [EXT-1:0]   row_sum, row_carry;
  logic [EXT-1:0]   total;
  logic [CNT_W-1:0] cnt;
  logic             excess;
  logic             beat;

  csa_row #(.W(EXT)) u_row (
    .a    (sum_r),
    .b    (carry_r),
    .c    (EXT'(in_data)),
    .sum  (row_sum),
    .carry(row_carry)
  );

  assign total = sum_r + carry_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ACC;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    beat     = 1'b0;
    case (state_q)
      ACC: begin
        in_ready = 1'b1;
        beat     = in_valid;
        if (in_valid && in_last) state_d = RESOLVE;
      end
      RESOLVE: state_d = OUT;
      OUT:     if (out_ready) state_d = ACC;
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_r     <= '0;
      carry_r   <= '0;
      cnt       <= '0;
      excess    <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
      out_count <= '0;
    end else begin
      if (beat) begin
        sum_r   <= row_sum;
        carry_r <= row_carry;
        // Count saturates; anything past MAX_BEATS may have wrapped the guard bits.
        if (cnt == MAX_CNT) excess <= 1'b1;
        else                cnt    <= cnt + CNT_W'(1);
      end
      if (state_q == RESOLVE) begin
        out_sum   <= total[WIDTH-1:0];
        out_ovf   <= (|total[EXT-1:WIDTH]) | excess;
        out_count <= cnt;
        out_valid <= 1'b1;
      end
      if (state_q == OUT && out_ready) begin
        out_valid <= 1'b0;
        sum_r     <= '0;
        carry_r   <= '0;
        cnt       <= '0;
        excess    <= 1'b0;
      end
    end
  end

endmodule
